input_conditioner: RTL and testbench
====================================

// Module: input_conditioner
// PURPOSE
//  Parametrised N-channel front end for board buttons/switches feeding the core top.
//  Per channel: metastability synchroniser, debounce filter, rise/fall edge pulses,
//  and optional auto-repeat while the input is held. It sits between the raw KEY/SW
//  pins and the core, replacing direct ~KEY / SW wiring.
// PARAMETERS
//  WIDTH          3        number of independent channels
//  SYNC_STAGES    2        synchroniser flops per channel (>=2)
//  DEBOUNCE_CYCLES 1_000_000 cycles an input must differ from level to be accepted (>=1)
//  REPEAT_DELAY   25_000_000 cycles from rise to first rpt pulse (>=1)
//  REPEAT_PERIOD  5_000_000  cycles between subsequent rpt pulses (>=1)
// PORTS
//  clk        in   1      system clock, single domain
//  rst_n      in   1      asynchronous active-low reset
//  din        in   WIDTH  raw asynchronous inputs, active-high (invert KEY outside)
//  repeat_en  in   WIDTH  per-channel auto-repeat enable, synchronous to clk
//  level      out  WIDTH  debounced level
//  rise       out  WIDTH  one-cycle pulse on level 0->1
//  fall       out  WIDTH  one-cycle pulse on level 1->0
//  rpt        out  WIDTH  one-cycle auto-repeat pulse while held
// BEHAVIOUR
//  - Reset: sync chain, level, rise, fall, rpt, and all counters = 0. Async assert,
//    registered release. Reset mid-debounce or mid-repeat discards all progress.
//  - Sync: s = last stage of the SYNC_STAGES chain. No logic on din before stage 0.
//  - Debounce per channel, counter dcnt, width $clog2(DEBOUNCE_CYCLES+1):
//    s==level -> dcnt<=0; s!=level and dcnt<DEBOUNCE_CYCLES-1 -> dcnt++;
//    s!=level and dcnt==DEBOUNCE_CYCLES-1 -> level<=s, dcnt<=0, rise/fall<=1 for 1 cycle.
//  - Latency: level, rise, and fall update on the (SYNC_STAGES+DEBOUNCE_CYCLES)th edge,
//    counting the first edge that samples the new din value. A glitch shorter than
//    DEBOUNCE_CYCLES cycles at s clears dcnt; it produces no level change and no pulse.
//  - rise and fall are registered and never both high. No pulse occurs when level is unchanged.
//  - Auto-repeat per channel, counter rcnt, width $clog2(max(DELAY,PERIOD)+1), phase bit first:
//    cleared (rcnt=0, first=1) while level==0 or repeat_en==0, and on the rise cycle.
//    While level==1 and repeat_en==1: rcnt++.
//    first && rcnt==REPEAT_DELAY-1 -> rpt=1, rcnt<=0, first<=0.
//    !first && rcnt==REPEAT_PERIOD-1 -> rpt=1, rcnt<=0.
//    The first rpt occurs REPEAT_DELAY cycles after the rise pulse. rpt never coincides with rise.
//  - repeat_en falling mid-hold: rpt is suppressed from the next cycle; re-enabling restarts
//    the count at the DELAY phase. On fall in the same cycle a rpt would fire, fall wins
//    and rpt=0.
//  - Inputs high at reset release are treated as new presses: rise after S+D edges.
//  - Channels are fully independent; simultaneous events on several channels are all
//    reported in the same cycle.
// STRUCTURE
//  - io_pkg: function clog2_max(a,b) for counter widths; local defaults for board
//    timing, e.g. CLK_HZ=50_000_000 and DEBOUNCE_MS-derived cycle constants.
//  - Sub-module input_conditioner_ch: one channel containing sync, debounce, and repeat.
//    The top level instantiates it WIDTH times in a generate loop; no shared state
//    between channels.
//  - All outputs come directly from flops.
// TESTING  (WIDTH=3, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5)
//  1 Reset: rst_n=0 with din=3'b000 -> all outputs 0. Release, hold 20 cycles -> no pulses.
//  2 Clean press: din[0] 0->1 sampled at edge k -> level[0]=1 and rise[0]=1 after edge k+5,
//    rise low after k+6. Release din[0] -> fall[0] after the 6th edge, 1 cycle wide.
//  3 Glitch: din[1] high for 3 cycles at s, then low -> level/rise/fall stay 0 and dcnt
//    returns to 0. Same test with 4 cycles -> rise[1] fires.
//  4 Repeat: repeat_en[2]=1, hold din[2] -> rise at T, rpt at T+10, T+15, T+20.
//    Drop repeat_en at T+17 -> no rpt at T+20. Release -> fall, no rpt.
//  5 Simultaneous: din=3'b111 on the same edge -> rise=3'b111 in one cycle. Then din[1]=0
//    -> only fall[1].
//  6 Reset mid-operation: assert rst_n at dcnt=2 and again during a hold with rcnt=7 ->
//    outputs 0 immediately (async). After release with din still high -> rise after 6 edges.

Source files
------------

// File: rtl/io_pkg.sv
// Shared constants and helpers for the button/switch input conditioner.
// Board defaults assume a 50 MHz clock.
package io_pkg;

    localparam int unsigned CLK_HZ         = 50_000_000;
    localparam int unsigned CYCLES_PER_MS  = CLK_HZ / 1000;
    localparam int unsigned DEBOUNCE_MS    = 20;
    localparam int unsigned REPEAT_DLY_MS  = 500;
    localparam int unsigned REPEAT_PER_MS  = 100;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = DEBOUNCE_MS * CYCLES_PER_MS;
    localparam int unsigned DEF_REPEAT_DELAY    = REPEAT_DLY_MS * CYCLES_PER_MS;
    localparam int unsigned DEF_REPEAT_PERIOD   = REPEAT_PER_MS * CYCLES_PER_MS;

    // Bits needed to hold values 0..max(a,b).
    function automatic int unsigned clog2_max(input int unsigned a, input int unsigned b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/input_conditioner_ch.sv
// One input channel: synchroniser, debounce filter, edge pulses and auto-repeat.
// Every output is driven straight from a flop.
module input_conditioner_ch
    import io_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    input  logic repeat_en,
    output logic level,
    output logic rise,
    output logic fall,
    output logic rpt
);

    localparam int unsigned DCW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned RCW = clog2_max(REPEAT_DELAY, REPEAT_PERIOD);

    localparam logic [DCW-1:0] DEB_LAST    = DCW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RCW-1:0] DELAY_LAST  = RCW'(REPEAT_DELAY - 1);
    localparam logic [RCW-1:0] PERIOD_LAST = RCW'(REPEAT_PERIOD - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [DCW-1:0]         dcnt_q, dcnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic [RCW-1:0]         rcnt_q, rcnt_d;
    logic                   first_q, first_d;
    logic                   rpt_q, rpt_d;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        dcnt_d  = dcnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (s == level_q) begin
            dcnt_d = '0;
        end else if (dcnt_q == DEB_LAST) begin
            level_d = s;
            dcnt_d  = '0;
            rise_d  = s;
            fall_d  = ~s;
        end else begin
            dcnt_d = dcnt_q + DCW'(1);
        end
    end

    // A release on the same edge as a due repeat pulse suppresses the pulse.
    always_comb begin
        rcnt_d  = rcnt_q;
        first_d = first_q;
        rpt_d   = 1'b0;
        if (!level_q || !repeat_en || fall_d) begin
            rcnt_d  = '0;
            first_d = 1'b1;
        end else if (first_q && (rcnt_q == DELAY_LAST)) begin
            rpt_d   = 1'b1;
            rcnt_d  = '0;
            first_d = 1'b0;
        end else if (!first_q && (rcnt_q == PERIOD_LAST)) begin
            rpt_d  = 1'b1;
            rcnt_d = '0;
        end else begin
            rcnt_d = rcnt_q + RCW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            dcnt_q  <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            rcnt_q  <= '0;
            first_q <= 1'b1;
            rpt_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], din};
            dcnt_q  <= dcnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            rcnt_q  <= rcnt_d;
            first_q <= first_d;
            rpt_q   <= rpt_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;
    assign rpt   = rpt_q;

endmodule

// File: rtl/input_conditioner.sv
// N-channel front end for raw board buttons/switches; channels share no state.
// Active-low KEY pins must be inverted before din.
module input_conditioner
    import io_pkg::*;
#(
    parameter int unsigned WIDTH           = 3,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] repeat_en,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] rpt
);

    for (genvar g = 0; g < WIDTH; g++) begin : g_ch
        input_conditioner_ch #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .din      (din[g]),
            .repeat_en(repeat_en[g]),
            .level    (level[g]),
            .rise     (rise[g]),
            .fall     (fall[g]),
            .rpt      (rpt[g])
        );
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner: directed scenarios plus randomized
// stimulus against a history-based reference model.
module tb_input_conditioner;

    localparam int W  = 3;
    localparam int S  = 2;
    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 5;
    localparam int HL = S + D - 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] din = '0;
    logic [W-1:0] repeat_en = '0;
    logic [W-1:0] level, rise, fall, rpt;

    input_conditioner #(
        .WIDTH          (W),
        .SYNC_STAGES    (S),
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .repeat_en(repeat_en),
        .level    (level),
        .rise     (rise),
        .fall     (fall),
        .rpt      (rpt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp_v);
        end
    endtask

    // Reference model. din_hist[c][j] is the din value sampled j+1 edges ago.
    // Level flips once the last D synchronised samples all disagree with it;
    // a repeat pulse is due when the enabled hold age hits RD, RD+RP, RD+2RP...
    logic [W-1:0] m_level = '0, m_rise = '0, m_fall = '0, m_rpt = '0;
    bit           din_hist [W][HL];
    int           age [W];

    initial begin
        bit all_diff;
        bit fire;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_level = '0; m_rise = '0; m_fall = '0; m_rpt = '0;
                for (int c = 0; c < W; c++) begin
                    age[c] = 0;
                    for (int j = 0; j < HL; j++) din_hist[c][j] = 1'b0;
                end
            end else begin
                for (int c = 0; c < W; c++) begin
                    all_diff = 1'b1;
                    for (int j = S - 1; j <= S + D - 2; j++)
                        if (din_hist[c][j] == m_level[c]) all_diff = 1'b0;
                    if (m_level[c] && repeat_en[c]) age[c]++;
                    else age[c] = 0;
                    fire = (age[c] >= RD) && (((age[c] - RD) % RP) == 0);
                    m_rise[c] = all_diff && !m_level[c];
                    m_fall[c] = all_diff && m_level[c];
                    if (all_diff) m_level[c] = ~m_level[c];
                    m_rpt[c] = fire && !m_fall[c];
                    for (int j = HL - 1; j > 0; j--) din_hist[c][j] = din_hist[c][j-1];
                    din_hist[c][0] = din[c];
                end
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int rise_cnt [W];
    int fall_cnt [W];
    int rpt_cnt  [W];
    int rise2_cyc = 0;
    int rpt2_q [$];

    // Per-cycle comparison against the model, plus pulse bookkeeping.
    initial begin
        for (int c = 0; c < W; c++) begin
            rise_cnt[c] = 0; fall_cnt[c] = 0; rpt_cnt[c] = 0;
        end
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("level", 32'(level), 32'(m_level));
                check("rise", 32'(rise), 32'(m_rise));
                check("fall", 32'(fall), 32'(m_fall));
                check("rpt", 32'(rpt), 32'(m_rpt));
                check("rise_fall_excl", 32'(rise & fall), 32'd0);
                for (int c = 0; c < W; c++) begin
                    rise_cnt[c] += int'(rise[c]);
                    fall_cnt[c] += int'(fall[c]);
                    rpt_cnt[c]  += int'(rpt[c]);
                end
                if (rise[2]) rise2_cyc = cyc;
                if (rpt[2]) rpt2_q.push_back(cyc - rise2_cyc);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    function automatic int pulses();
        int t = 0;
        for (int c = 0; c < W; c++) t += rise_cnt[c] + fall_cnt[c] + rpt_cnt[c];
        return t;
    endfunction

    initial begin
        int base;
        int hold [W];
        int ch;

        // Reset state and quiet idle period.
        tick(3);
        check("reset_outputs", 32'({level, rise, fall, rpt}), 32'd0);
        rst_n = 1'b1;
        tick(20);
        check("idle_pulses", 32'(pulses()), 32'd0);

        // Clean press and release on channel 0.
        din[0] = 1'b1;
        tick(5);
        check("press_level_early", 32'(level[0]), 32'd0);
        tick(1);
        check("press_level", 32'(level[0]), 32'd1);
        check("press_rise", 32'(rise[0]), 32'd1);
        tick(1);
        check("press_rise_width", 32'(rise[0]), 32'd0);
        din[0] = 1'b0;
        tick(5);
        check("release_fall_early", 32'(fall[0]), 32'd0);
        tick(1);
        check("release_fall", 32'(fall[0]), 32'd1);
        check("release_level", 32'(level[0]), 32'd0);
        tick(1);
        check("release_fall_width", 32'(fall[0]), 32'd0);

        // Glitches on channel 1: three cycles rejected, four accepted.
        base = rise_cnt[1];
        din[1] = 1'b1;
        tick(3);
        din[1] = 1'b0;
        tick(10);
        check("glitch3_level", 32'(level[1]), 32'd0);
        check("glitch3_rise", 32'(rise_cnt[1] - base), 32'd0);
        din[1] = 1'b1;
        tick(4);
        din[1] = 1'b0;
        tick(14);
        check("glitch4_rise", 32'(rise_cnt[1] - base), 32'd1);

        // Auto-repeat on channel 2, enable dropped at T+17.
        rpt2_q.delete();
        repeat_en = 3'b100;
        din[2] = 1'b1;
        tick(6);
        check("rep_rise", 32'(rise[2]), 32'd1);
        tick(17);
        repeat_en[2] = 1'b0;
        tick(10);
        check("rep_count", 32'(rpt2_q.size()), 32'd2);
        if (rpt2_q.size() >= 2) begin
            check("rep_first_at", 32'(rpt2_q[0]), 32'd10);
            check("rep_second_at", 32'(rpt2_q[1]), 32'd15);
        end
        base = fall_cnt[2];
        din[2] = 1'b0;
        tick(12);
        check("rep_fall", 32'(fall_cnt[2] - base), 32'd1);
        check("rep_after_fall", 32'(rpt2_q.size()), 32'd2);

        // Simultaneous press on all channels, then release of channel 1 only.
        din = 3'b111;
        tick(6);
        check("sim_rise", 32'(rise), 32'b111);
        din = 3'b101;
        tick(6);
        check("sim_fall", 32'(fall), 32'b010);
        check("sim_no_rise", 32'(rise), 32'd0);
        check("sim_level", 32'(level), 32'b101);

        // Reset mid-debounce.
        din = 3'b000;
        tick(8);
        din = 3'b001;
        tick(4);
        rst_n = 1'b0;
        #1;
        check("rst_debounce_out", 32'({level, rise, fall, rpt}), 32'd0);
        tick(1);
        rst_n = 1'b1;
        din = 3'b111;
        repeat_en = 3'b111;
        tick(6);
        check("rst_rel_rise", 32'(rise), 32'b111);

        // Reset during a held repeat with rcnt at 7.
        tick(7);
        check("hold_level", 32'(level), 32'b111);
        rst_n = 1'b0;
        #1;
        check("rst_hold_out", 32'({level, rise, fall, rpt}), 32'd0);
        tick(1);
        rst_n = 1'b1;
        tick(5);
        check("rst2_level_early", 32'(level), 32'd0);
        tick(1);
        check("rst2_rise", 32'(rise), 32'b111);
        tick(9);
        check("rst2_no_rpt_yet", 32'(rpt), 32'd0);
        tick(1);
        check("rst2_rpt", 32'(rpt), 32'b111);

        // Randomized run against the model.
        for (int c = 0; c < W; c++) hold[c] = 1;
        for (int i = 0; i < 4000; i++) begin
            tick(1);
            for (int c = 0; c < W; c++) begin
                hold[c]--;
                if (hold[c] <= 0) begin
                    din[c] = ~din[c];
                    hold[c] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5))
                                                          : int'($urandom_range(6, 45));
                end
            end
            if ($urandom_range(0, 59) == 0) begin
                ch = int'($urandom_range(0, W - 1));
                repeat_en[ch] = ~repeat_en[ch];
            end
            if (i == 2500) begin
                #1 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
